periph_apb_bridge: RTL and testbench



---
 rtl/periph_apb_bridge_if.sv | 25 ++
 rtl/periph_apb_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_periph_apb_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/periph_apb_bridge_if.sv
// Core-side request/response channel of the peripheral APB bridge.
// The requester uses the master modport; the bridge uses the slave modport.
interface periph_apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, addr_i, we_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/periph_apb_bridge.sv
// Single-master bridge from the core data interface onto the peripheral APB.
// Decodes 0x1A10_0000..0x1A10_8FFF into a one-hot slave select (4 KiB per
// slave), sequences SETUP/ACCESS and answers unmapped addresses locally with
// an error. Address decode assumes APB_ADDR_WIDTH >= 32.
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN (ACCESS-phase wait limit).
module periph_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NB_SLAVES      = 9,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    periph_apb_bridge_if.slave                  core,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic                                pwrite_o,
    output logic [NB_SLAVES-1:0]                psel_o,
    output logic                                penable_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVES-1:0]                pready_i,
    input  logic [NB_SLAVES-1:0]                pslverr_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]                state_q,   state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                      we_q,      we_d;
    logic [NB_SLAVES-1:0]      psel_q,    psel_d;
    logic                      penable_q, penable_d;
    logic                      rvalid_q,  rvalid_d;
    logic                      err_q,     err_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q,   rdata_d;

    logic                      gnt_s;
    logic [NB_SLAVES-1:0]      dec_sel_s;
    logic [APB_DATA_WIDTH-1:0] prdata_sel_s;
    logic                      pready_sel_s;
    logic                      pslverr_sel_s;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (($clog2(TIMEOUT_CYCLES) + 1) > 8) ? ($clog2(TIMEOUT_CYCLES) + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    // Without the wait counter the timeout length has no effect; keep it
    // referenced so the parameter list stays identical across builds.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Address map decode: one 4 KiB window per slave above 0x1A10_0000; DEBUG
    // at 0x1A11_xxxx has no select line and falls out as unmapped.
    always_comb begin
        dec_sel_s = '0;
        if (core.addr_i[31:16] == 16'h1A10) begin
            for (int k = 0; k < NB_SLAVES; k++) begin
                if (core.addr_i[15:12] == 4'(k)) begin
                    dec_sel_s[k] = 1'b1;
                end else begin
                    dec_sel_s[k] = 1'b0;
                end
            end
        end else begin
            dec_sel_s = '0;
        end
    end

    // Observe only the selected slave's ready, error and read data.
    always_comb begin
        prdata_sel_s  = '0;
        pready_sel_s  = |(pready_i & psel_q);
        pslverr_sel_s = |(pslverr_i & psel_q);
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (psel_q[k]) begin
                prdata_sel_s = prdata_sel_s | prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end else begin
                prdata_sel_s = prdata_sel_s;
            end
        end
    end

    // Transfer FSM and next-state values of every registered output.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        gnt_s     = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_s = core.req_i & ~rst;
                if (gnt_s) begin
                    addr_d  = core.addr_i;
                    wdata_d = core.wdata_i;
                    we_d    = core.we_i;
                    if (|dec_sel_s) begin
                        psel_d  = dec_sel_s;
                        state_d = ST_SETUP;
                    end else begin
                        // Unmapped: answer locally, never touch the bus.
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready_sel_s) begin
                    rvalid_d  = 1'b1;
                    err_d     = pslverr_sel_s;
                    rdata_d   = we_q ? '0 : prdata_sel_s;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
`ifdef APB_BRIDGE_TIMEOUT_EN
                    if (wait_cnt_q == CNT_LAST) begin
                        rvalid_d  = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        psel_d    = '0;
                        penable_d = 1'b0;
                        state_d   = ST_RESP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        state_d    = ST_ACCESS;
                    end
`else
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign core.gnt_o    = gnt_s;
    assign core.rvalid_o = rvalid_q;
    assign core.rdata_o  = rdata_q;
    assign core.err_o    = err_q;
    assign paddr_o       = addr_q;
    assign pwdata_o      = wdata_q;
    assign pwrite_o      = we_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;

endmodule

// File: tb/tb_periph_apb_bridge.sv
// Directed testbench for periph_apb_bridge. Stimulus is applied 1 ns after
// the rising edge and outputs are sampled 1 ns later.
module tb_periph_apb_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pwrite;
    logic [NS-1:0]   psel;
    logic            penable;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [NS-1:0]   pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    periph_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    periph_apb_bridge #(
        .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NB_SLAVES(NS), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .core(bus),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
        .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_prdata(input logic [NS-1:0] tgt, input logic [31:0] val);
        for (int k = 0; k < NS; k++) begin
            prdata[k*DW +: DW] = tgt[k] ? val : (32'hDEAD_0000 | 32'(k));
        end
    endtask

    // One complete transfer starting in an IDLE cycle; checks every cycle.
    task automatic do_xfer(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wd, input int waits, input logic [31:0] slv_rd,
                           input logic slv_err, input logic [NS-1:0] exp_sel,
                           input logic exp_err, input logic [31:0] exp_rd);
        fill_prdata(exp_sel, slv_rd);
        bus.req_i = 1'b1; bus.addr_i = addr; bus.we_i = we; bus.wdata_i = wd;
        #1;
        chk({tag, "_gnt"}, 64'(bus.gnt_o), 64'd1);
        chk({tag, "_psel_c0"}, 64'(psel), 64'd0);
        next_cycle();
        bus.req_i = 1'b0; bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
        if (exp_sel != '0) begin
            #1;
            chk({tag, "_setup_psel"}, 64'(psel), 64'(exp_sel));
            chk({tag, "_setup_pen"}, 64'(penable), 64'd0);
            chk({tag, "_pwrite"}, 64'(pwrite), 64'(we));
            chk({tag, "_paddr"}, 64'(paddr), 64'(addr));
            chk({tag, "_pwdata"}, 64'(pwdata), 64'(wd));
            next_cycle();
            for (int w = 0; w <= waits; w++) begin
                if (w == waits) begin
                    pready  = '1;
                    pslverr = slv_err ? '1 : ~exp_sel;
                end else begin
                    pready  = ~exp_sel;
                    pslverr = ~exp_sel;
                end
                #1;
                chk({tag, "_acc_psel"}, 64'(psel), 64'(exp_sel));
                chk({tag, "_acc_pen"}, 64'(penable), 64'd1);
                chk({tag, "_acc_paddr"}, 64'(paddr), 64'(addr));
                chk({tag, "_acc_rvalid"}, 64'(bus.rvalid_o), 64'd0);
                next_cycle();
            end
            pready = '0; pslverr = '0;
        end
        bus.req_i = 1'b1;
        #1;
        chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'd1);
        chk({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
        chk({tag, "_rdata"}, 64'(bus.rdata_o), 64'(exp_rd));
        chk({tag, "_resp_psel"}, 64'(psel), 64'd0);
        chk({tag, "_resp_pen"}, 64'(penable), 64'd0);
        chk({tag, "_resp_gnt"}, 64'(bus.gnt_o), 64'd0);
        bus.req_i = 1'b0;
        next_cycle();
        chk({tag, "_rvalid_drop"}, 64'(bus.rvalid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  seen;
        rst = 1'b1;
        bus.req_i = 1'b1; bus.addr_i = 32'h1A10_1000; bus.we_i = 1'b1; bus.wdata_i = 32'h1;
        pready = '0; pslverr = '0;
        fill_prdata('0, 32'h0);
        next_cycle();
        next_cycle();
        chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        chk("rst_rdata", 64'(bus.rdata_o), 64'd0);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_pen", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        bus.req_i = 1'b0;
        rst = 1'b0;
        next_cycle();

        do_xfer("gpio_wr", 32'h1A10_1004, 1'b1, 32'hCAFE_0001, 0, 32'h7777_7777, 1'b0, 9'h002, 1'b0, 32'h0);
        do_xfer("timer_rd", 32'h1A10_3008, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 9'h008, 1'b0, 32'h1234_5678);
        do_xfer("unmap_rd", 32'h1A10_9000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h0);
        do_xfer("i2c_err", 32'h1A10_5000, 1'b0, 32'h0, 2, 32'h55AA_0000, 1'b1, 9'h020, 1'b1, 32'h55AA_0000);
        do_xfer("debug_wr", 32'h1A11_0004, 1'b1, 32'hFFFF_0000, 0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h0);
        do_xfer("kuz_rd", 32'h1A10_8FFC, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 9'h100, 1'b0, 32'h0BAD_F00D);
        do_xfer("low_rd", 32'h0000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h0);
        do_xfer("uart_wr", 32'h1A10_0FFC, 1'b1, 32'h0000_00A5, 0, 32'hAAAA_AAAA, 1'b0, 9'h001, 1'b0, 32'h0);

        // Reset while a SPI read is stalled in ACCESS.
        bus.req_i = 1'b1; bus.addr_i = 32'h1A10_2000; bus.we_i = 1'b0;
        #1;
        chk("spi_gnt", 64'(bus.gnt_o), 64'd1);
        next_cycle();
        bus.req_i = 1'b0;
        #1;
        chk("spi_setup_psel", 64'(psel), 64'h004);
        next_cycle();
        #1;
        chk("spi_acc_pen", 64'(penable), 64'd1);
        rst = 1'b1;
        next_cycle();
        bus.req_i = 1'b1; bus.addr_i = 32'h1A10_1010;
        #1;
        chk("midrst_psel", 64'(psel), 64'd0);
        chk("midrst_pen", 64'(penable), 64'd0);
        chk("midrst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("midrst_gnt", 64'(bus.gnt_o), 64'd0);
        next_cycle();
        chk("midrst_rvalid2", 64'(bus.rvalid_o), 64'd0);
        rst = 1'b0;
        do_xfer("post_rst", 32'h1A10_1010, 1'b0, 32'h0, 1, 32'hA5A5_0101, 1'b0, 9'h002, 1'b0, 32'hA5A5_0101);

        // UART read whose slave never becomes ready.
        pready = '0; pslverr = '0;
        bus.req_i = 1'b1; bus.addr_i = 32'h1A10_0000; bus.we_i = 1'b0;
        #1;
        chk("to_gnt", 64'(bus.gnt_o), 64'd1);
        lat = 0;
        seen = 1'b0;
        while (lat < 1000 && !seen) begin
            next_cycle();
            bus.req_i = 1'b0;
            lat++;
            if (bus.rvalid_o) seen = 1'b1;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        chk("to_latency", 64'(lat), 64'd18);
        chk("to_err", 64'(bus.err_o), 64'd1);
        chk("to_rdata", 64'(bus.rdata_o), 64'd0);
        chk("to_psel", 64'(psel), 64'd0);
        chk("to_pen", 64'(penable), 64'd0);
`else
        chk("noto_rvalid", 64'(seen), 64'd0);
        chk("noto_psel", 64'(psel), 64'h001);
        chk("noto_pen", 64'(penable), 64'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("noto_rst_psel", 64'(psel), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
